// File: rtl/mem_pkg.sv
// Shared types for the word-RAM access adapter and its load alignment helper.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DATA   = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [3:0] WB_NONE = 4'b0000;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_access_adapter_load_align.sv
// Picks the addressed byte/half lane out of a RAM word and sign/zero extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        sign_ext,
  output logic [31:0] value
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;

  always_comb begin
    byte_shift = word >> {offset, 3'b000};
    half_shift = word >> {offset[1], 4'b0000};
    value      = word;
    case (size)
      SZ_BYTE: value = {{24{sign_ext & byte_shift[7]}}, byte_shift[7:0]};
      SZ_HALF: value = {{16{sign_ext & half_shift[15]}}, half_shift[15:0]};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/mem_access_adapter.sv
// Byte-addressed load/store front end for a single-port word RAM with a
// one-cycle registered read. One transaction in flight at a time.
module mem_access_adapter
  import mem_pkg::*;
#(
  parameter int          MEMORY_BUS_WIDTH = 32,
  parameter int          SIZE             = 2048,
  parameter logic [31:0] ADDRESS          = 32'h0,
  localparam int         AW               = $clog2(SIZE)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [1:0]                  req_size,
  input  logic                        req_signed,
  input  logic [31:0]                 req_addr,
  input  logic [MEMORY_BUS_WIDTH-1:0] req_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [MEMORY_BUS_WIDTH-1:0] rsp_rdata,
  output logic                        rsp_err,
  output logic                        mem_enable,
  output logic [AW-1:0]               mem_addr,
  output logic [3:0]                  mem_wb,
  output logic [MEMORY_BUS_WIDTH-1:0] mem_wdata,
  input  logic [MEMORY_BUS_WIDTH-1:0] mem_rdata,
  output logic [31:0]                 stat_rd,
  output logic [31:0]                 stat_wr,
  output logic [31:0]                 stat_err
);

  localparam logic [32:0] LIMIT = 33'(4 * SIZE);

  // Handshake: a request moves on a rising edge with req_valid & req_ready,
  // a response retires on a rising edge with rsp_valid & rsp_ready; rsp_valid
  // and rsp_rdata hold steady until then.
  state_e      state, state_next;
  size_e       size_q;
  logic        sign_q;
  logic        we_q;
  logic [1:0]  lane_q;
  logic [3:0]  wb_q;

  logic [31:0] off;
  logic        accept;
  logic        req_err;
  logic [3:0]  wb_calc;
  logic [31:0] wdata_calc;
  logic [31:0] aligned;

  always_comb begin
    off     = req_addr - ADDRESS;
    accept  = (state == IDLE) && req_valid;
    req_err = (req_addr < ADDRESS) || ({1'b0, off} >= LIMIT) ||
              (req_size == 2'd3) ||
              ((req_size == 2'd1) && off[0]) ||
              ((req_size == 2'd2) && (off[1:0] != 2'b00));
    wb_calc    = WB_NONE;
    wdata_calc = req_wdata;
    case (req_size)
      2'd0: begin
        wb_calc    = 4'b0001 << off[1:0];
        wdata_calc = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        wb_calc    = 4'b0011 << off[1:0];
        wdata_calc = {2{req_wdata[15:0]}};
      end
      default: wb_calc = 4'b1111;
    endcase
    if (!req_we) wb_calc = WB_NONE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    mem_enable = 1'b0;
    mem_wb     = WB_NONE;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_enable = 1'b1;
        mem_wb     = wb_q;
        state_next = we_q ? RESP : DATA;
      end
      DATA: state_next = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  load_align u_load_align (
    .word     (mem_rdata),
    .offset   (lane_q),
    .size     (size_q),
    .sign_ext (sign_q),
    .value    (aligned)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_q      <= WB_NONE;
      size_q    <= SZ_BYTE;
      sign_q    <= 1'b0;
      we_q      <= 1'b0;
      lane_q    <= 2'b00;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      stat_rd   <= '0;
      stat_wr   <= '0;
      stat_err  <= '0;
    end else if (accept) begin
      rsp_rdata <= '0;
      rsp_err   <= req_err;
      if (req_err) begin
        stat_err <= sat_inc(stat_err);
      end else begin
        mem_addr  <= off[2 +: AW];
        mem_wdata <= wdata_calc;
        wb_q      <= wb_calc;
        size_q    <= size_e'(req_size);
        sign_q    <= req_signed;
        we_q      <= req_we;
        lane_q    <= off[1:0];
        if (req_we) stat_wr <= sat_inc(stat_wr);
        else        stat_rd <= sat_inc(stat_rd);
      end
    end else if (state == DATA) begin
      rsp_rdata <= aligned;
    end
  end

endmodule
